lut_cfg_loader: RTL and testbench
=================================

Name: lut_cfg_loader

Overview:
- Serial configuration writer for a column of L_FRAG 4-input LUT fragments.
- Accepts a 1-bit configuration stream under a valid/ready handshake and deserialises it into one 16-bit truth-table word per fragment.
- Drives the parallel fragBitInfo inputs of NUM_FRAGS fragments.
- Sits between the fabric configuration controller and the logic-cell array.

Parameters:
- NUM_FRAGS, 4, number of L_FRAG fragments programmed per load sequence (1..16).
- FRAG_BITS, 16, truth-table bits per fragment; fixed at 16 to match a 4-input LUT.
- IDX_W, 2, width of the fragment index; equals clog2(NUM_FRAGS), minimum 1.

Ports:
- clk  input  1  configuration clock.
- reset  input  1  synchronous, active-high reset.
- cfg_start  input  1  single-cycle request to begin a load sequence; ignored unless in IDLE.
- cfg_abort  input  1  terminate the load in progress and return to IDLE.
- cfg_data  input  1  serial configuration bit.
- cfg_valid  input  1  cfg_data is valid this cycle.
- cfg_ready  output  1  loader accepts a bit this cycle.
- frag_bit_info  output  NUM_FRAGS*16  concatenated truth tables; fragment k occupies bits [16k+15:16k].
- cfg_busy  output  1  high in LOAD.
- cfg_done  output  1  one-cycle pulse when the last fragment commits.
- cfg_frag_idx  output  IDX_W  index of the fragment currently being shifted.

Behaviour:
- Reset (synchronous, active-high, on clk):
  - State goes to IDLE.
  - frag_bit_info, shift register, bit counter and cfg_frag_idx all clear to 0.
  - cfg_ready, cfg_busy and cfg_done are 0.
- States: IDLE, LOAD, DONE.
- IDLE:
  - cfg_ready=0.
  - cfg_start=1 moves to LOAD on the next edge and clears the bit counter and the index.
  - cfg_valid is ignored; no bits are consumed.
- LOAD:
  - cfg_ready=1 and cfg_busy=1.
  - A bit is accepted on any edge where cfg_valid&&cfg_ready.
  - Bit order is LSB first: the first accepted bit of a fragment becomes fragBitInfo[0], the 16th becomes [15]. This matches LUT addressing {I3,I2,I1,I0}.
  - Fragments load in order 0, 1, ..., NUM_FRAGS-1.
  - The bit counter (4 bits) wraps 15->0.
- Commit:
  - On the edge accepting bit 15, slice k of frag_bit_info is loaded with {cfg_data, shift[14:0]} atomically.
  - The slice is visible the cycle after acceptance.
  - Partial words never reach frag_bit_info. All other slices hold their values.
- Index:
  - cfg_frag_idx increments on each commit.
  - On the commit of fragment NUM_FRAGS-1, the state goes to DONE and the index wraps to 0.
- DONE:
  - cfg_done=1 and cfg_ready=0 for exactly one cycle, then IDLE.
  - Back-to-back sequences: cfg_start in the DONE cycle is ignored; it must be issued in IDLE.
- cfg_valid=0 in LOAD: the loader stalls indefinitely with no timeout, and all state holds.
- cfg_abort:
  - Has priority over bit acceptance in the same cycle.
  - Moves to IDLE, discards the partial shift word and clears the counter and the index.
  - Fragments already committed keep their new values. Uncommitted fragments keep their previous values.
  - No cfg_done is generated.
- cfg_start while in LOAD or DONE has no effect.
- Reset asserted mid-LOAD overrides everything, including a commit edge; all slices return to 0.
- Throughput is 1 bit/cycle, so a full load takes NUM_FRAGS*16 accepted bits plus 1 DONE cycle.

Decomposition:
- Shared package:
  - State enum (IDLE/LOAD/DONE).
  - FRAG_BITS=16 constant.
  - A helper function returning the slice base offset 16*k.
- One natural sub-module, lut_cfg_shifter: a 16-bit serial-in/parallel-out shift register with a 4-bit counter and a word_complete strobe.
- The top-level loader holds the FSM, the index and the frag_bit_info commit registers.

Test Plan:
- Basic load: after reset, pulse cfg_start, then stream fragments 0x8000, 0xFFFE, 0x6996, 0xAAAA LSB first with cfg_valid held high.
  - Expect frag_bit_info=0xAAAA_6996_FFFE_8000.
  - Expect a cfg_done pulse exactly 1 cycle after the 64th accepted bit.
  - Expect cfg_busy high for 64 cycles.
- Atomic commit: stream 15 bits of 0x1234 to fragment 0.
  - Slice 0 stays 0x0000 until the 16th bit.
  - Slice 0 becomes 0x1234 on the following cycle, with cfg_frag_idx 0->1.
- Stall: randomly deassert cfg_valid (about 50%) during the basic-load stream.
  - Same final frag_bit_info and one cfg_done.
  - No bit accepted while cfg_valid=0.
- Abort: load fragment 0=0x00FF, then abort after 7 bits of fragment 1, on the same cycle as a valid bit.
  - Slice 0=0x00FF, slice 1 unchanged at 0x0000.
  - State IDLE, no cfg_done.
  - The next cfg_start restarts at index 0.
- Start while busy / in DONE: pulse cfg_start at bit 20 and again in the DONE cycle.
  - Neither pulse restarts the sequence; the load completes normally and the loader ends in IDLE.
- Reset mid-load: assert reset on the edge that would commit fragment 2 with 0xFFFF.
  - All slices read 0 and the state is IDLE the next cycle.
  - cfg_ready=0 and cfg_done=0.

Source files
------------

// File: rtl/lut_cfg_loader_pkg.sv
// rtl/lut_cfg_loader_pkg.sv - shared constants, states and helpers for the LUT configuration loader
package lut_cfg_loader_pkg;

    localparam int FRAG_BITS = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        STATE_IDLE = ST_IDLE,
        STATE_LOAD = ST_LOAD,
        STATE_DONE = ST_DONE
    } state_e;

    function automatic int slice_base(input int k);
        return FRAG_BITS * k;
    endfunction

endpackage

// File: rtl/lut_cfg_loader_shifter.sv
// rtl/lut_cfg_loader_shifter.sv - serial-in/parallel-out truth-table word assembler
module lut_cfg_shifter
    import lut_cfg_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 data,
    output logic [FRAG_BITS-1:0] word,
    output logic                 word_complete
);

    // Only 15 bits are stored: the 16th arrives live and completes the word.
    logic [FRAG_BITS-2:0] shift_q;
    logic [3:0]           bit_cnt;

    assign word_complete = shift_en && (bit_cnt == 4'd15);
    assign word          = {data, shift_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shift_q <= {data, shift_q[FRAG_BITS-2:1]};
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/lut_cfg_loader.sv
// rtl/lut_cfg_loader.sv - serial configuration writer for a column of 4-input LUT fragments
module lut_cfg_loader
    import lut_cfg_loader_pkg::*;
#(
    parameter int NUM_FRAGS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_start,
    input  logic                           cfg_abort,
    input  logic                           cfg_data,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    output logic [NUM_FRAGS*FRAG_BITS-1:0] frag_bit_info,
    output logic                           cfg_busy,
    output logic                           cfg_done,
    output logic [IDX_W-1:0]               cfg_frag_idx
);

    logic [1:0]           state;
    logic                 accept;
    logic                 shifter_clear;
    logic [FRAG_BITS-1:0] word;
    logic                 word_complete;
    logic                 last_frag;

    assign cfg_ready = (state == ST_LOAD);
    assign cfg_busy  = (state == ST_LOAD);
    assign cfg_done  = (state == ST_DONE);

    // Abort wins over a bit presented in the same cycle.
    assign accept        = (state == ST_LOAD) && cfg_valid && !cfg_abort;
    assign shifter_clear = ((state == ST_IDLE) && cfg_start) ||
                           ((state == ST_LOAD) && cfg_abort);
    assign last_frag     = (cfg_frag_idx == IDX_W'(NUM_FRAGS - 1));

    lut_cfg_shifter u_shifter (
        .clk           (clk),
        .reset         (reset),
        .clear         (shifter_clear),
        .shift_en      (accept),
        .data          (cfg_data),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cfg_frag_idx  <= '0;
            frag_bit_info <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state        <= ST_LOAD;
                        cfg_frag_idx <= '0;
                    end
                end
                ST_LOAD: begin
                    if (cfg_abort) begin
                        state        <= ST_IDLE;
                        cfg_frag_idx <= '0;
                    end else if (word_complete) begin
                        for (int k = 0; k < NUM_FRAGS; k++) begin
                            if (cfg_frag_idx == IDX_W'(k)) begin
                                frag_bit_info[slice_base(k) +: FRAG_BITS] <= word;
                            end
                        end
                        if (last_frag) begin
                            state        <= ST_DONE;
                            cfg_frag_idx <= '0;
                        end else begin
                            cfg_frag_idx <= cfg_frag_idx + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb/tb_lut_cfg_loader.sv - directed self-checking bench for lut_cfg_loader
module tb_lut_cfg_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic        cfg_abort;
    logic        cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [63:0] frag_bit_info;
    logic        cfg_busy;
    logic        cfg_done;
    logic [1:0]  cfg_frag_idx;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    localparam logic [63:0] BASIC = 64'hAAAA_6996_FFFE_8000;

    lut_cfg_loader #(.NUM_FRAGS(4), .IDX_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .frag_bit_info (frag_bit_info),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_frag_idx  (cfg_frag_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_done) done_cnt++;
        if (cfg_busy) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_data = 1'b0;
        cfg_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Streams bits [nbits-1:0] of v LSB first; optional random stalls drive inverted garbage.
    task automatic send_stream(input logic [63:0] v, input int nbits, input bit stall, input int start_at);
        logic [63:0] vv;
        vv = v;
        for (int n = 0; n < nbits; n++) begin
            while (stall && ($urandom_range(1) == 1)) begin
                cfg_valid = 1'b0;
                cfg_data = ~vv[n];
                tick();
            end
            cfg_start = (n == start_at);
            cfg_valid = 1'b1;
            cfg_data = vv[n];
            tick();
            cfg_start = 1'b0;
        end
        cfg_valid = 1'b0;
        cfg_data = 1'b0;
    endtask

    initial begin
        do_reset();
        check("reset_frag", frag_bit_info, 64'h0);
        check("reset_ready", {63'h0, cfg_ready}, 64'h0);
        check("reset_busy", {63'h0, cfg_busy}, 64'h0);
        check("reset_done", {63'h0, cfg_done}, 64'h0);
        check("reset_idx", {62'h0, cfg_frag_idx}, 64'h0);

        // IDLE ignores valid bits
        cfg_valid = 1'b1;
        cfg_data = 1'b1;
        tick();
        tick();
        cfg_valid = 1'b0;
        check("idle_ready", {63'h0, cfg_ready}, 64'h0);

        // basic load
        busy_cnt = 0;
        done_cnt = 0;
        start();
        check("load_busy", {63'h0, cfg_busy}, 64'h1);
        check("load_ready", {63'h0, cfg_ready}, 64'h1);
        send_stream(BASIC, 64, 1'b0, -1);
        check("basic_done_pulse", {63'h0, cfg_done}, 64'h1);
        check("basic_done_ready", {63'h0, cfg_ready}, 64'h0);
        check("basic_frag", frag_bit_info, BASIC);
        tick();
        check("basic_done_gone", {63'h0, cfg_done}, 64'h0);
        check("basic_busy_cycles", 64'(busy_cnt), 64'd64);
        check("basic_done_count", 64'(done_cnt), 64'd1);

        // atomic commit
        do_reset();
        start();
        send_stream(64'h1234, 15, 1'b0, -1);
        check("atomic_partial", frag_bit_info, 64'h0);
        check("atomic_idx0", {62'h0, cfg_frag_idx}, 64'h0);
        cfg_valid = 1'b1;
        cfg_data = 1'b0;
        tick();
        cfg_valid = 1'b0;
        check("atomic_commit", frag_bit_info, 64'h1234);
        check("atomic_idx1", {62'h0, cfg_frag_idx}, 64'h1);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("atomic_abort_idle", {63'h0, cfg_ready}, 64'h0);

        // stalled load
        do_reset();
        done_cnt = 0;
        start();
        send_stream(BASIC, 64, 1'b1, -1);
        check("stall_done_pulse", {63'h0, cfg_done}, 64'h1);
        tick();
        check("stall_frag", frag_bit_info, BASIC);
        check("stall_done_count", 64'(done_cnt), 64'd1);

        // abort mid fragment 1 together with a valid bit
        do_reset();
        done_cnt = 0;
        start();
        send_stream(64'h00FF, 16, 1'b0, -1);
        send_stream(64'h7F, 7, 1'b0, -1);
        check("abort_idx_before", {62'h0, cfg_frag_idx}, 64'h1);
        cfg_valid = 1'b1;
        cfg_data = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        check("abort_frag", frag_bit_info, 64'h00FF);
        check("abort_ready", {63'h0, cfg_ready}, 64'h0);
        check("abort_busy", {63'h0, cfg_busy}, 64'h0);
        check("abort_idx", {62'h0, cfg_frag_idx}, 64'h0);
        tick();
        check("abort_no_done", 64'(done_cnt), 64'd0);
        start();
        check("restart_busy", {63'h0, cfg_busy}, 64'h1);
        check("restart_idx", {62'h0, cfg_frag_idx}, 64'h0);
        send_stream(64'h5A5A, 16, 1'b0, -1);
        check("restart_frag", frag_bit_info, 64'h5A5A);
        check("restart_idx1", {62'h0, cfg_frag_idx}, 64'h1);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;

        // start while busy and in DONE
        do_reset();
        done_cnt = 0;
        start();
        send_stream(BASIC, 64, 1'b0, 20);
        check("busy_start_done", {63'h0, cfg_done}, 64'h1);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("done_start_idle_ready", {63'h0, cfg_ready}, 64'h0);
        check("done_start_idle_busy", {63'h0, cfg_busy}, 64'h0);
        tick();
        check("done_start_still_idle", {63'h0, cfg_busy}, 64'h0);
        check("busy_start_frag", frag_bit_info, BASIC);
        check("busy_start_done_count", 64'(done_cnt), 64'd1);

        // reset on the fragment-2 commit edge
        do_reset();
        start();
        send_stream(64'hFFFF_2222_1111, 47, 1'b0, -1);
        check("prereset_frag", frag_bit_info, 64'h2222_1111);
        check("prereset_idx", {62'h0, cfg_frag_idx}, 64'h2);
        reset = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = 1'b1;
        tick();
        reset = 1'b0;
        cfg_valid = 1'b0;
        check("midreset_frag", frag_bit_info, 64'h0);
        check("midreset_ready", {63'h0, cfg_ready}, 64'h0);
        check("midreset_done", {63'h0, cfg_done}, 64'h0);
        check("midreset_busy", {63'h0, cfg_busy}, 64'h0);
        check("midreset_idx", {62'h0, cfg_frag_idx}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
